// File: rtl/dma_bus_target.sv
// X16 expansion-bus target: decodes a 2^AW-byte window at BASE onto internal byte RAM,
// answering reads after WAIT_STATES stall cycles and accepting writes with zero wait.
module dma_bus_target #(
   parameter logic [15:0] BASE        = 16'h4000,
   parameter int          AW          = 8,
   parameter int          WAIT_STATES = 1
) (
   input  logic        PHI2,
   input  logic        RST,
   input  logic        VALID,
   input  logic        RWB,
   input  logic [15:0] ADDR,
   input  logic [7:0]  DIN,
   output logic [7:0]  DOUT,
   output logic        DOUT_EN,
   output logic        STALL,
   output logic [15:0] HIT_CNT,
   output logic [1:0]  dbg_state
);

   // Bus handshake: a cycle is presented when VALID is high at a rising PHI2 edge.
   // While STALL is high the initiator holds ADDR/RWB/VALID and this target ignores them;
   // DOUT_EN high means DOUT carries read data, sampled by the initiator at the next edge.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt;
   logic [AW-1:0]   lat_off;
   logic [AW-1:0]   offset;
   logic            hit, accept, rd_req, wr_req;
   logic [1:0]      hit_inc;
   logic [7:0]      mem [2**AW];

   assign offset  = ADDR[AW-1:0];
   assign hit     = VALID && (ADDR[15:AW] == BASE[15:AW]);
   assign accept  = (state == S_IDLE) || (state == S_DATA);
   assign rd_req  = accept && hit && RWB;
   assign wr_req  = accept && hit && !RWB;
   // A DATA edge completes a read; a write accepted on that same edge counts as well.
   assign hit_inc = {1'b0, state == S_DATA} + {1'b0, wr_req};

   always_ff @(posedge PHI2) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE, S_DATA: begin
            if (rd_req) state_nxt = (WAIT_STATES == 0) ? S_DATA : S_WAIT;
            else        state_nxt = S_IDLE;
         end
         S_WAIT:  state_nxt = (cnt == 4'd0) ? S_DATA : S_WAIT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      STALL     = (state == S_WAIT);
      DOUT_EN   = (state == S_DATA);
      dbg_state = state;
   end

   // RAM is deliberately left out of reset so scratch contents survive a bus reset.
   always_ff @(posedge PHI2) begin
      if (wr_req && !RST) mem[offset] <= DIN;
   end

   always_ff @(posedge PHI2) begin
      if (RST) begin
         cnt     <= 4'd0;
         lat_off <= '0;
         DOUT    <= 8'h00;
         HIT_CNT <= 16'h0000;
      end else begin
         HIT_CNT <= HIT_CNT + {14'd0, hit_inc};
         if (rd_req) begin
            if (WAIT_STATES == 0) begin
               DOUT <= mem[offset];
            end else begin
               lat_off <= offset;
               cnt     <= 4'(WAIT_STATES - 1);
            end
         end
         // Data is fetched at the load edge so it reflects the latest RAM contents.
         if (state == S_WAIT) begin
            if (cnt == 4'd0) DOUT <= mem[lat_off];
            else             cnt  <= cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_dma_bus_target.sv
// Directed bench for dma_bus_target: five instances share one bus and differ only in
// WAIT_STATES (index 0:1, 1:0, 2:3, 3:15, 4:4); each test watches the instance it targets.
module tb_dma_bus_target;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        rwb = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  din = 8'h00;

   logic [7:0]  dout      [5];
   logic [15:0] hit_cnt   [5];
   logic [1:0]  dbg_state [5];
   logic [4:0]  dout_en;
   logic [4:0]  stall;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : (g == 3) ? 15 : 4;
      dma_bus_target #(.BASE(16'h4000), .AW(8), .WAIT_STATES(WS)) u_dut (
         .PHI2(clk), .RST(rst), .VALID(valid), .RWB(rwb), .ADDR(addr), .DIN(din),
         .DOUT(dout[g]), .DOUT_EN(dout_en[g]), .STALL(stall[g]), .HIT_CNT(hit_cnt[g]),
         .dbg_state(dbg_state[g])
      );
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_all();
      rst = 1'b1; valid = 1'b0; rwb = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      valid = 1'b1; rwb = 1'b0; addr = a; din = d;
      tick();
      valid = 1'b0; rwb = 1'b1;
   endtask

   // Issues a read and holds it through the stall; wiggle makes the initiator misbehave.
   task automatic do_read(input int k, input logic [15:0] a, input bit wiggle,
                          output int stalls, output logic [7:0] data, output logic en);
      valid = 1'b1; rwb = 1'b1; addr = a; din = 8'h00;
      tick();
      stalls = 0;
      while (stall[k] && stalls < 40) begin
         stalls++;
         if (wiggle) begin
            addr = a ^ 16'h0001; rwb = 1'b0; din = 8'hEE;
         end
         tick();
      end
      data = dout[k];
      en   = dout_en[k];
      valid = 1'b0; rwb = 1'b1; addr = a;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_all();
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if ({dout[k], dout_en[k], stall[k], hit_cnt[k]} !== 26'd0)
            $display("FAIL reset_state[%0d]: got dout=%h en=%b stall=%b cnt=%h want all zero",
                     k, dout[k], dout_en[k], stall[k], hit_cnt[k]);
         else n_pass++;
      end
      for (int i = 0; i < 6; i++) begin
         valid = ~valid; rwb = i[0]; addr = 16'h9F00; din = 8'h3C;
         tick();
         n_checks++;
         if ({dout[0], dout_en[0], stall[0], hit_cnt[0]} !== 26'd0)
            $display("FAIL miss_idle: got dout=%h en=%b stall=%b cnt=%h want all zero",
                     dout[0], dout_en[0], stall[0], hit_cnt[0]);
         else n_pass++;
      end
      valid = 1'b0;
   endtask

   task automatic test_write_read();
      reset_all();
      valid = 1'b1; rwb = 1'b0; addr = 16'h4010; din = 8'hA5;
      tick();
      valid = 1'b0; rwb = 1'b1;
      n_checks++;
      if (hit_cnt[0] !== 16'd1 || stall[0] !== 1'b0 || dout_en[0] !== 1'b0)
         $display("FAIL write_accept: got cnt=%h stall=%b en=%b want 0001 0 0",
                  hit_cnt[0], stall[0], dout_en[0]);
      else n_pass++;
      valid = 1'b1; rwb = 1'b1; addr = 16'h4010;
      tick();
      n_checks++;
      if (stall[0] !== 1'b1 || dout_en[0] !== 1'b0)
         $display("FAIL read_stall: got stall=%b en=%b want 1 0", stall[0], dout_en[0]);
      else n_pass++;
      tick();
      valid = 1'b0;
      n_checks++;
      if (stall[0] !== 1'b0 || dout_en[0] !== 1'b1 || dout[0] !== 8'hA5 || hit_cnt[0] !== 16'd1)
         $display("FAIL read_data: got stall=%b en=%b dout=%h cnt=%h want 0 1 a5 0001",
                  stall[0], dout_en[0], dout[0], hit_cnt[0]);
      else n_pass++;
      tick();
      n_checks++;
      if (dout_en[0] !== 1'b0 || dout[0] !== 8'hA5 || hit_cnt[0] !== 16'd2)
         $display("FAIL read_complete: got en=%b dout=%h cnt=%h want 0 a5 0002",
                  dout_en[0], dout[0], hit_cnt[0]);
      else n_pass++;
   endtask

   task automatic test_wr_hazard();
      reset_all();
      valid = 1'b1; rwb = 1'b0; addr = 16'h4011; din = 8'h5C;
      tick();
      rwb = 1'b1;
      tick();
      valid = 1'b0;
      n_checks++;
      if (dout_en[1] !== 1'b1 || dout[1] !== 8'h5C)
         $display("FAIL write_then_read: got en=%b dout=%h want 1 5c", dout_en[1], dout[1]);
      else n_pass++;
      tick();
   endtask

   task automatic test_wait_sweep();
      int         ks [3];
      int         wss[3];
      int         k, st;
      logic [7:0] d;
      logic       en;
      ks  = '{1, 2, 3};
      wss = '{0, 3, 15};
      for (int j = 0; j < 3; j++) begin
         k = ks[j];
         reset_all();
         do_write(16'h4020, 8'h5A);
         do_write(16'h4021, 8'hC3);
         do_read(k, 16'h4020, 1'b1, st, d, en);
         n_checks++;
         if (st !== wss[j] || d !== 8'h5A || en !== 1'b1)
            $display("FAIL sweep_ws%0d: got stalls=%0d dout=%h en=%b want %0d 5a 1",
                     wss[j], st, d, en, wss[j]);
         else n_pass++;
         tick();
         n_checks++;
         if (dout_en[k] !== 1'b0 || hit_cnt[k] !== 16'd3)
            $display("FAIL sweep_done_ws%0d: got en=%b cnt=%h want 0 0003",
                     wss[j], dout_en[k], hit_cnt[k]);
         else n_pass++;
         do_read(k, 16'h4021, 1'b0, st, d, en);
         tick();
         n_checks++;
         if (d !== 8'hC3)
            $display("FAIL sweep_ignore_ws%0d: got dout=%h want c3", wss[j], d);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] s, e, d;
      int         st;
      logic       en;
      reset_all();
      for (int i = 0; i < 8; i++) begin
         s = 8'(8'h10 + i * 8'h13);
         do_write(16'h4000 + 16'(i), s);
      end
      reset_all();
      exp_q.delete();
      valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s = 8'(8'h10 + i * 8'h13);
         rwb = 1'b1; addr = 16'h4000 + 16'(i);
         tick();
         n_checks++;
         if (dout_en[1] !== 1'b1 || dout[1] !== s)
            $display("FAIL b2b_read[%0d]: got en=%b dout=%h want 1 %h", i, dout_en[1], dout[1], s);
         else n_pass++;
         exp_q.push_back(s);
         rwb = 1'b0; addr = 16'h40F0 + 16'(i); din = dout[1];
         tick();
         n_checks++;
         if (dout_en[1] !== 1'b0)
            $display("FAIL b2b_write[%0d]: got en=%b want 0", i, dout_en[1]);
         else n_pass++;
      end
      valid = 1'b0; rwb = 1'b1;
      n_checks++;
      if (hit_cnt[1] !== 16'd16)
         $display("FAIL b2b_count: got %h want 0010", hit_cnt[1]);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         do_read(1, 16'h40F0 + 16'(i), 1'b0, st, d, en);
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (d !== e || en !== 1'b1)
            $display("FAIL b2b_copy[%0d]: got dout=%h en=%b want %h 1", i, d, en, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_read();
      int         st;
      logic [7:0] d;
      logic       en, pulse;
      reset_all();
      do_write(16'h4033, 8'h77);
      valid = 1'b1; rwb = 1'b1; addr = 16'h4033;
      tick();
      n_checks++;
      if (stall[4] !== 1'b1)
         $display("FAIL midrst_stall: got %b want 1", stall[4]);
      else n_pass++;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; valid = 1'b0;
      n_checks++;
      if (stall[4] !== 1'b0 || dout_en[4] !== 1'b0 || hit_cnt[4] !== 16'd0)
         $display("FAIL midrst_abort: got stall=%b en=%b cnt=%h want 0 0 0000",
                  stall[4], dout_en[4], hit_cnt[4]);
      else n_pass++;
      pulse = 1'b0;
      repeat (6) begin
         tick();
         if (dout_en[4] !== 1'b0) pulse = 1'b1;
      end
      n_checks++;
      if (pulse !== 1'b0)
         $display("FAIL midrst_no_pulse: got pulse=%b want 0", pulse);
      else n_pass++;
      do_read(4, 16'h4033, 1'b0, st, d, en);
      tick();
      n_checks++;
      if (st !== 4 || d !== 8'h77 || en !== 1'b1)
         $display("FAIL midrst_ram_kept: got stalls=%0d dout=%h en=%b want 4 77 1", st, d, en);
      else n_pass++;
   endtask

   task automatic test_wrap_and_decode();
      int         st;
      logic [7:0] d;
      logic       en;
      reset_all();
      valid = 1'b1; rwb = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         addr = 16'h4000 | 16'(i & 255);
         din  = 8'(i);
         tick();
      end
      valid = 1'b0; rwb = 1'b1;
      n_checks++;
      if (hit_cnt[0] !== 16'hFFFF)
         $display("FAIL cnt_preload: got %h want ffff", hit_cnt[0]);
      else n_pass++;
      do_write(16'h40FF, 8'h3C);
      n_checks++;
      if (hit_cnt[0] !== 16'h0000)
         $display("FAIL cnt_wrap: got %h want 0000", hit_cnt[0]);
      else n_pass++;
      do_read(0, 16'h40FF, 1'b0, st, d, en);
      tick();
      n_checks++;
      if (d !== 8'h3C || en !== 1'b1 || hit_cnt[0] !== 16'h0001)
         $display("FAIL top_offset: got dout=%h en=%b cnt=%h want 3c 1 0001", d, en, hit_cnt[0]);
      else n_pass++;
      do_write(16'h4100, 8'h99);
      n_checks++;
      if (hit_cnt[0] !== 16'h0001 || stall[0] !== 1'b0 || dout_en[0] !== 1'b0)
         $display("FAIL miss_above: got cnt=%h stall=%b en=%b want 0001 0 0",
                  hit_cnt[0], stall[0], dout_en[0]);
      else n_pass++;
      do_read(0, 16'h4000, 1'b0, st, d, en);
      tick();
      n_checks++;
      if (d !== 8'h00)
         $display("FAIL miss_no_alias: got dout=%h want 00", d);
      else n_pass++;
      valid = 1'b1; rwb = 1'b1; addr = 16'h3FFF;
      tick();
      n_checks++;
      if (stall[0] !== 1'b0 || dout_en[0] !== 1'b0)
         $display("FAIL miss_below: got stall=%b en=%b want 0 0", stall[0], dout_en[0]);
      else n_pass++;
      tick();
      valid = 1'b0;
      n_checks++;
      if (stall[0] !== 1'b0 || dout_en[0] !== 1'b0 || hit_cnt[0] !== 16'h0002)
         $display("FAIL miss_below_hold: got stall=%b en=%b cnt=%h want 0 0 0002",
                  stall[0], dout_en[0], hit_cnt[0]);
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write_read();
      test_wr_hazard();
      test_wait_sweep();
      test_back_to_back();
      test_reset_mid_read();
      test_wrap_and_decode();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
